// File: rtl/dmem_pkg.sv
// Shared definitions for the pentaRV data memory: funct3 encodings, dump
// FSM states and the load formatting helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } dump_state_e;

  // Align the addressed byte/half to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  funct3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_B:    res = {{24{sh[7]}}, sh[7:0]};
      F3_H:    res = {{16{sh[15]}}, sh[15:0]};
      F3_W:    res = word;
      F3_BU:   res = {24'd0, sh[7:0]};
      F3_HU:   res = {16'd0, sh[15:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_dump_fsm.sv
// Dump engine: walks the word pointer over the whole array with a
// valid/ready handshake and pulses done after the last accepted word.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no dump; core has the memory; dump_req starts a dump
//   STREAM | presenting mem[ptr]; ptr advances on each accepted word
//   DONE   | last word accepted; dump_done pulses, back to IDLE next
module dmem_dump_fsm
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dump_req,
  input  logic                     dump_ready,
  output logic                     busy,
  output logic                     dump_valid,
  output logic [$clog2(DEPTH)-1:0] dump_addr,
  output logic                     dump_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  dump_state_e      state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = STREAM;
          ptr_d   = '0;
        end
      end
      STREAM: begin
        if (dump_ready) begin
          // Natural wrap of the pointer leaves it at 0 for the next dump.
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign dump_valid = (state_q == STREAM);
  assign dump_done  = (state_q == DONE);
  assign dump_addr  = ptr_q;

endmodule

// File: rtl/dmem_ctrl.sv
// pentaRV MEM-stage data memory: byte-addressed, word-organised array with
// funct3 store/load formatting, misalign suppression and a streaming dump port.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 0,
  parameter int DUMP_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     we,
  input  logic [2:0]               funct3,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [31:0]              wd,
  output logic [31:0]              rd,
  output logic                     rd_valid,
  output logic                     misalign,
  output logic                     busy,
  input  logic                     dump_req,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [$clog2(DEPTH)-1:0] dump_addr,
  output logic [31:0]              dump_data,
  output logic                     dump_done
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             bad;
  logic             load_req;
  logic             wr_en;
  logic [3:0]       wmask;
  logic [31:0]      wdata;
  logic [31:0]      rd_word;

  assign idx = addr[IDX_W+1:2];
  assign off = addr[1:0];

  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic addr_unused;
    assign addr_unused = ^addr[ADDR_W-1:IDX_W+2];
  end

  always_comb begin
    case (funct3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = |off;
      default:     bad = 1'b1;
    endcase
  end

  assign misalign = en & bad;
  assign load_req = en & ~we & ~busy;
  assign wr_en    = en & we & ~bad & ~busy;

  // Data is replicated across lanes so the mask alone selects what lands.
  always_comb begin
    wmask = 4'b0000;
    wdata = wd;
    case (funct3)
      F3_B: begin
        wmask = 4'b0001 << off;
        wdata = {4{wd[7:0]}};
      end
      F3_H: begin
        wmask = 4'b0011 << off;
        wdata = {2{wd[15:0]}};
      end
      F3_W:    wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read before the write edge, so a same-word store is never forwarded.
  assign rd_word = mem_q[idx];

  if (READ_LAT != 0) begin : g_rd_reg
    logic        vld_q, vld_d;
    logic        ok_q, ok_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;

    always_comb begin
      vld_d  = load_req;
      ok_d   = load_req & ~bad;
      word_d = rd_word;
      off_d  = off;
      f3_d   = funct3;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q  <= 1'b0;
        ok_q   <= 1'b0;
        word_q <= '0;
        off_q  <= '0;
        f3_q   <= '0;
      end else begin
        vld_q  <= vld_d;
        ok_q   <= ok_d;
        word_q <= word_d;
        off_q  <= off_d;
        f3_q   <= f3_d;
      end
    end

    assign rd_valid = rst & vld_q;
    assign rd       = (rst && ok_q) ? load_fmt(word_q, off_q, f3_q) : '0;
  end else begin : g_rd_comb
    assign rd_valid = rst & load_req;
    assign rd       = (rst && load_req && !bad) ? load_fmt(rd_word, off, funct3) : '0;
  end

  if (DUMP_EN != 0) begin : g_dump
    dmem_dump_fsm #(
      .DEPTH(DEPTH)
    ) u_dump_fsm (
      .clk        (clk),
      .rst        (rst),
      .dump_req   (dump_req),
      .dump_ready (dump_ready),
      .busy       (busy),
      .dump_valid (dump_valid),
      .dump_addr  (dump_addr),
      .dump_done  (dump_done)
    );
    assign dump_data = dump_valid ? mem_q[dump_addr] : '0;
  end else begin : g_no_dump
    logic dump_unused;
    assign dump_unused = dump_req ^ dump_ready;
    assign busy        = 1'b0;
    assign dump_valid  = 1'b0;
    assign dump_addr   = '0;
    assign dump_data   = '0;
    assign dump_done   = 1'b0;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data memory for the pentaRV core's MEM stage: byte-addressed, word-organised.
- Stores are formatted from funct3 (SB/SH/SW) with byte-lane masking; loads are formatted from funct3 (LB/LH/LW/LBU/LHU) with sign/zero extension.
- Misaligned accesses are flagged and suppressed.
- A hardware dump engine streams the whole array out over a valid/ready port, word by word, so the testbench can log it without touching memory internals.

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two, minimum 4.
- ADDR_W, 32: byte-address width; the word index is addr[$clog2(DEPTH)+1:2], upper bits ignored.
- READ_LAT, 0: load latency. 0 = combinational read. 1 = registered read.
- DUMP_EN, 1: 0 removes the dump FSM; dump outputs are tied to 0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset (asserted when 0)
- en  input  1  access valid this cycle
- we  input  1  1 = store, 0 = load; qualified by en
- funct3  input  3  RV32I load/store size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr  input  ADDR_W  byte address
- wd  input  32  store data, right-aligned
- rd  output  32  formatted load data
- rd_valid  output  1  rd is valid (en & !we, delayed by READ_LAT)
- misalign  output  1  access is misaligned or funct3 is illegal; combinational with the request
- busy  output  1  dump in progress; core must stall
- dump_req  input  1  start dump (level sampled)
- dump_valid  output  1  dump word presented
- dump_ready  input  1  consumer accepts the dump word
- dump_addr  output  $clog2(DEPTH)  word index of dump_data
- dump_data  output  32  mem[dump_addr]
- dump_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset: rd, rd_valid, dump_valid, dump_done and busy are 0; FSM goes to IDLE; dump pointer is 0. Memory contents are not reset.
- While rst=0, rd is forced to 0 in both latency modes.
- Alignment:
  - H/HU need addr[0]=0.
  - W needs addr[1:0]=0.
  - Any funct3 not listed above also sets misalign.
  - A misaligned store writes nothing. A misaligned load returns rd=0 with rd_valid still asserted.
- Store, on posedge clk when en & we & !misalign & !busy:
  - SB: mask = 0001<<addr[1:0]; data = wd[7:0] replicated to all four lanes.
  - SH: mask = 0011<<addr[1:0]; data = wd[15:0] replicated to both halves.
  - SW: mask = 1111; data = wd.
  - Only masked lanes are updated.
- Load formatting:
  - Byte = word >> (8*addr[1:0]); half = word >> (8*addr[1:0]).
  - Sign-extend for B/H, zero-extend for BU/HU.
  - READ_LAT=0: rd is valid in the same cycle.
  - READ_LAT=1: word, addr[1:0] and funct3 are registered; rd and rd_valid appear one cycle after the request.
- Read-during-write to the same word returns the old contents in both modes.
- Accesses with busy=1 are ignored (no write, rd_valid=0).
- Dump FSM (DUMP_EN=1), states IDLE, STREAM, DONE:
  - IDLE: if dump_req=1 → STREAM, ptr=0, busy=1. A store in that same cycle completes (it is sampled before busy rises).
  - STREAM: dump_valid=1, dump_addr=ptr, dump_data=mem[ptr] (combinational from the array).
    - On dump_valid & dump_ready: ptr+1.
    - If ptr==DEPTH-1 → DONE.
    - dump_data must hold while ready=0.
  - DONE: dump_done=1 for one cycle, busy drops → IDLE. ptr wraps to 0.
  - dump_req while in STREAM/DONE is ignored.
  - dump_req held high re-triggers only after returning to IDLE.
- Reset mid-dump aborts immediately: dump_valid=0, no dump_done.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - dump state enum: IDLE, STREAM, DONE
  - function load_fmt(word, off, funct3)
- One natural sub-module: dmem_dump_fsm (pointer, state, handshake), instantiated under DUMP_EN.
- Array, store formatting and load path stay in the top.

Test Plan:
1. Lane stores:
   - SW 0xDEADBEEF @0x10, then SB 0x55 @0x12 → LW @0x10 returns 0xDE55BEEF.
   - LBU @0x13 returns 0x000000DE; LB @0x13 returns 0xFFFFFFDE.
2. Halfword and misalign:
   - SH 0x8001 @0x22 → LH @0x22 returns 0xFFFF8001; LHU returns 0x00008001.
   - SW @0x21 sets misalign=1 and leaves the word at 0x20 unchanged.
3. READ_LAT=1:
   - LW @0x10 in cycle n → rd_valid=1 with 0xDE55BEEF in cycle n+1, 0 in cycle n.
   - Read-during-write to the same word returns the old value.
4. Dump with backpressure (DEPTH=16, mem[i]=i*0x11111111):
   - Pulse dump_req; toggle dump_ready 1/0.
   - Expect 16 accepted beats with dump_addr 0..15 in order, data stable while ready=0.
   - dump_done for exactly one cycle, busy=0 afterwards.
5. Stall and collision:
   - Store in the same cycle as dump_req is written (visible as dump beat).
   - Stores issued while busy=1 leave memory unchanged (checked after the dump).
6. Reset mid-dump:
   - Assert rst=0 at beat 5 → dump_valid, busy and rd all 0 asynchronously.
   - After release, a new dump_req restarts at dump_addr=0.
